card_flip_game_ctrl: RTL and testbench

Game sequencer for the Card-Flip design. It accepts card selections from the board's input logic and reads each card's pair identity from an external deck store. It tracks face-up and matched cards, holds mismatched pairs visible for a fixed time, and counts attempts. It also issues the `game_start` / `game_end` pulses that run and stop the elapsed-time counter feeding the HEX displays.

---
 rtl/card_flip_game_ctrl_if.sv | 21 ++
 rtl/card_flip_game_ctrl.sv | 155 +++++++++++++++
 tb/tb_card_flip_game_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/card_flip_game_ctrl_if.sv
// rtl/card_flip_game_ctrl_if.sv - card selection strobe and deck store lookup bundle
interface card_flip_game_ctrl_if;
    logic       sel_valid;
    logic [3:0] card_sel;
    logic [3:0] deck_addr;
    logic [2:0] deck_pair;

    modport master (
        output sel_valid,
        output card_sel,
        output deck_pair,
        input  deck_addr
    );

    modport slave (
        input  sel_valid,
        input  card_sel,
        input  deck_pair,
        output deck_addr
    );
endinterface

// File: rtl/card_flip_game_ctrl.sv
// rtl/card_flip_game_ctrl.sv - Card-Flip game sequencer: picks, match check, mismatch hold, move count
// Optional MOVE_LIMIT_EN: a mismatch on move MAX_MOVES ends the game with lose.
module card_flip_game_ctrl #(
    parameter int unsigned HOLD_CYCLES = 50000000,
    parameter int unsigned MAX_MOVES   = 30
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    card_flip_game_ctrl_if.slave        sel_bus,
    output logic [15:0]                 face_up,
    output logic [15:0]                 matched,
    output logic [7:0]                  moves,
    output logic                        game_start,
    output logic                        game_end,
    output logic                        win,
    output logic                        lose
);
    typedef enum logic [2:0] {IDLE, PICK1, PICK2, CHECK, HOLD, DONE} state_t;

    localparam logic [25:0] HOLD_LAST = 26'(HOLD_CYCLES - 1);
`ifdef MOVE_LIMIT_EN
    localparam logic [7:0] MOVE_LIMIT = 8'(MAX_MOVES);
`endif

    state_t      state, state_n;
    logic [15:0] face_up_n, matched_n;
    logic [7:0]  moves_n;
    logic        game_start_n, game_end_n, win_n, lose_n;
    logic [3:0]  idx1, idx2, idx1_n, idx2_n;
    logic [2:0]  pair1, pair2, pair1_n, pair2_n;
    logic [25:0] hold_cnt, hold_cnt_n;
    logic [15:0] sel_bit, pair_bits;
    logic        pick_ok;

    assign sel_bus.deck_addr = sel_bus.card_sel;
    assign sel_bit   = 16'(1) << sel_bus.card_sel;
    assign pair_bits = (16'(1) << idx1) | (16'(1) << idx2);
    // Already-shown cards (including matched ones) cannot be picked again.
    assign pick_ok   = sel_bus.sel_valid && ((face_up & sel_bit) == 16'h0000);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            face_up    <= '0;
            matched    <= '0;
            moves      <= '0;
            game_start <= 1'b0;
            game_end   <= 1'b0;
            win        <= 1'b0;
            lose       <= 1'b0;
            idx1       <= '0;
            idx2       <= '0;
            pair1      <= '0;
            pair2      <= '0;
            hold_cnt   <= '0;
        end else begin
            state      <= state_n;
            face_up    <= face_up_n;
            matched    <= matched_n;
            moves      <= moves_n;
            game_start <= game_start_n;
            game_end   <= game_end_n;
            win        <= win_n;
            lose       <= lose_n;
            idx1       <= idx1_n;
            idx2       <= idx2_n;
            pair1      <= pair1_n;
            pair2      <= pair2_n;
            hold_cnt   <= hold_cnt_n;
        end
    end

    always_comb begin
        state_n      = state;
        face_up_n    = face_up;
        matched_n    = matched;
        moves_n      = moves;
        game_start_n = 1'b0;
        game_end_n   = 1'b0;
        win_n        = win;
        lose_n       = lose;
        idx1_n       = idx1;
        idx2_n       = idx2;
        pair1_n      = pair1;
        pair2_n      = pair2;
        hold_cnt_n   = hold_cnt;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    face_up_n    = '0;
                    matched_n    = '0;
                    moves_n      = '0;
                    win_n        = 1'b0;
                    lose_n       = 1'b0;
                    game_start_n = 1'b1;
                    state_n      = PICK1;
                end
            end
            PICK1: begin
                if (pick_ok) begin
                    idx1_n    = sel_bus.card_sel;
                    pair1_n   = sel_bus.deck_pair;
                    face_up_n = face_up | sel_bit;
                    state_n   = PICK2;
                end
            end
            PICK2: begin
                if (pick_ok) begin
                    idx2_n    = sel_bus.card_sel;
                    pair2_n   = sel_bus.deck_pair;
                    face_up_n = face_up | sel_bit;
                    moves_n   = (moves == 8'hFF) ? moves : moves + 8'd1;
                    state_n   = CHECK;
                end
            end
            CHECK: begin
                if (pair1 == pair2) begin
                    matched_n = matched | pair_bits;
                    if (&matched_n) begin
                        game_end_n = 1'b1;
                        win_n      = 1'b1;
                        state_n    = DONE;
                    end else begin
                        state_n = PICK1;
                    end
                end else begin
`ifdef MOVE_LIMIT_EN
                    if (moves == MOVE_LIMIT) begin
                        game_end_n = 1'b1;
                        lose_n     = 1'b1;
                        state_n    = DONE;
                    end else begin
                        hold_cnt_n = '0;
                        state_n    = HOLD;
                    end
`else
                    hold_cnt_n = '0;
                    state_n    = HOLD;
`endif
                end
            end
            HOLD: begin
                if (hold_cnt == HOLD_LAST) begin
                    face_up_n = face_up & ~pair_bits;
                    state_n   = PICK1;
                end else begin
                    hold_cnt_n = hold_cnt + 26'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_card_flip_game_ctrl.sv
// tb/tb_card_flip_game_ctrl.sv - table-driven, scoreboarded bench for card_flip_game_ctrl
module tb_card_flip_game_ctrl;
    localparam int HOLD = 4;
`ifdef MOVE_LIMIT_EN
    localparam int MAXM = 2;
`else
    localparam int MAXM = 30;
`endif

    typedef struct {
        logic        rst;
        logic        st;
        logic        sv;
        logic [3:0]  sel;
        logic [15:0] fu;
        logic [15:0] mt;
        logic [7:0]  mv;
        logic        gs;
        logic        ge;
        logic        wn;
        logic        ls;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] face_up, matched;
    logic [7:0]  moves;
    logic        game_start, game_end, win, lose;

    card_flip_game_ctrl_if bus ();
    assign bus.deck_pair = bus.deck_addr[2:0];

    card_flip_game_ctrl #(.HOLD_CYCLES(HOLD), .MAX_MOVES(MAXM)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .sel_bus    (bus.slave),
        .face_up    (face_up),
        .matched    (matched),
        .moves      (moves),
        .game_start (game_start),
        .game_end   (game_end),
        .win        (win),
        .lose       (lose)
    );

    always #5 clk = ~clk;

    vec_t tab[$];
    vec_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    function automatic void chk(string nm, int row, logic [15:0] act, logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s row %0d actual=%h required=%h", nm, row, act, req);
        end
    endfunction

    function automatic void add(logic rst, logic st, logic sv, logic [3:0] sel, logic [15:0] fu,
                                logic [15:0] mt, logic [7:0] mv, logic gs, logic ge, logic wn, logic ls);
        vec_t v;
        v.rst = rst; v.st = st; v.sv = sv; v.sel = sel; v.fu = fu; v.mt = mt;
        v.mv = mv; v.gs = gs; v.ge = ge; v.wn = wn; v.ls = ls;
        tab.push_back(v);
    endfunction

    task automatic step(input vec_t v, input int row);
        vec_t e;
        reset         = v.rst;
        start         = v.st;
        bus.sel_valid = v.sv;
        bus.card_sel  = v.sel;
        exp_q.push_back(v);
        #1;
        if (v.sv) chk("deck_addr", row, 16'(bus.deck_addr), 16'(v.sel));
        @(negedge clk);
        e = exp_q.pop_front();
        chk("face_up",    row, face_up,           e.fu);
        chk("matched",    row, matched,           e.mt);
        chk("moves",      row, 16'(moves),        16'(e.mv));
        chk("game_start", row, 16'(game_start),   16'(e.gs));
        chk("game_end",   row, 16'(game_end),     16'(e.ge));
        chk("win",        row, 16'(win),          16'(e.wn));
        chk("lose",       row, 16'(lose),         16'(e.ls));
    endtask

    initial begin
        logic [15:0] fu, mt;
        logic [7:0]  mv;
        int          ge_seen;

        reset = 1'b1; start = 1'b0; bus.sel_valid = 1'b0; bus.card_sel = 4'd0;
        #2;
        chk("reset_face_up", -1, face_up, 16'h0000);
        chk("reset_moves",   -1, 16'(moves), 16'h0000);
        chk("reset_flags",   -1, {12'h0, game_start, game_end, win, lose}, 16'h0000);

        // game A: basic match, repeated / matched / mid-game start ignored
        add(1,0,0,0,  16'h0000,16'h0000,0, 0,0,0,0);
        add(0,1,0,0,  16'h0000,16'h0000,0, 1,0,0,0);
        add(0,0,0,0,  16'h0000,16'h0000,0, 0,0,0,0);
        add(0,0,1,3,  16'h0008,16'h0000,0, 0,0,0,0);
        add(0,0,1,3,  16'h0008,16'h0000,0, 0,0,0,0);
        add(0,0,1,11, 16'h0808,16'h0000,1, 0,0,0,0);
        add(0,0,1,6,  16'h0808,16'h0808,1, 0,0,0,0);
        add(0,0,1,4,  16'h0818,16'h0808,1, 0,0,0,0);
        add(0,0,1,4,  16'h0818,16'h0808,1, 0,0,0,0);
        add(0,0,1,3,  16'h0818,16'h0808,1, 0,0,0,0);
        add(0,0,1,12, 16'h1818,16'h0808,2, 0,0,0,0);
        add(0,0,0,0,  16'h1818,16'h1818,2, 0,0,0,0);
        add(0,0,1,11, 16'h1818,16'h1818,2, 0,0,0,0);
        add(0,1,0,0,  16'h1818,16'h1818,2, 0,0,0,0);

        // game B: mismatch held exactly HOLD cycles after entering HOLD
        add(1,0,0,0,  16'h0000,16'h0000,0, 0,0,0,0);
        add(0,1,0,0,  16'h0000,16'h0000,0, 1,0,0,0);
        add(0,0,1,2,  16'h0004,16'h0000,0, 0,0,0,0);
        add(0,0,1,5,  16'h0024,16'h0000,1, 0,0,0,0);
        add(0,0,0,0,  16'h0024,16'h0000,1, 0,0,0,0);
        add(0,0,1,7,  16'h0024,16'h0000,1, 0,0,0,0);
        add(0,0,1,9,  16'h0024,16'h0000,1, 0,0,0,0);
        add(0,0,0,0,  16'h0024,16'h0000,1, 0,0,0,0);
        add(0,0,0,0,  16'h0000,16'h0000,1, 0,0,0,0);
        add(0,0,1,2,  16'h0004,16'h0000,1, 0,0,0,0);

        // game C: match every pair, win, then restart
        add(1,0,0,0,  16'h0000,16'h0000,0, 0,0,0,0);
        add(0,1,0,0,  16'h0000,16'h0000,0, 1,0,0,0);
        fu = '0; mt = '0; mv = '0;
        for (int p = 0; p < 8; p++) begin
            fu = fu | (16'(1) << p);
            add(0,0,1,4'(p), fu, mt, mv, 0,0,0,0);
            fu = fu | (16'(1) << (p + 8));
            mv = mv + 8'd1;
            add(0,0,1,4'(p + 8), fu, mt, mv, 0,0,0,0);
            mt = fu;
            add(0,0,0,0, fu, mt, mv, 0, (p == 7), (p == 7), 0);
        end
        add(0,0,1,0,  16'hFFFF,16'hFFFF,8, 0,0,1,0);
        add(0,1,0,0,  16'h0000,16'h0000,0, 1,0,0,0);
        add(0,0,0,0,  16'h0000,16'h0000,0, 0,0,0,0);

`ifdef MOVE_LIMIT_EN
        // game D: second mismatch with MAX_MOVES=2 loses, pair left face-up
        add(1,0,0,0,  16'h0000,16'h0000,0, 0,0,0,0);
        add(0,1,0,0,  16'h0000,16'h0000,0, 1,0,0,0);
        add(0,0,1,2,  16'h0004,16'h0000,0, 0,0,0,0);
        add(0,0,1,5,  16'h0024,16'h0000,1, 0,0,0,0);
        for (int k = 0; k < HOLD; k++) add(0,0,0,0, 16'h0024,16'h0000,1, 0,0,0,0);
        add(0,0,0,0,  16'h0000,16'h0000,1, 0,0,0,0);
        add(0,0,1,2,  16'h0004,16'h0000,1, 0,0,0,0);
        add(0,0,1,5,  16'h0024,16'h0000,2, 0,0,0,0);
        add(0,0,0,0,  16'h0024,16'h0000,2, 0,1,0,1);
        add(0,0,0,0,  16'h0024,16'h0000,2, 0,0,0,1);
`endif

        // game E: walk into the 2nd HOLD cycle before the async reset below
        add(1,0,0,0,  16'h0000,16'h0000,0, 0,0,0,0);
        add(0,1,0,0,  16'h0000,16'h0000,0, 1,0,0,0);
        add(0,0,1,2,  16'h0004,16'h0000,0, 0,0,0,0);
        add(0,0,1,5,  16'h0024,16'h0000,1, 0,0,0,0);
        add(0,0,0,0,  16'h0024,16'h0000,1, 0,0,0,0);
        add(0,0,0,0,  16'h0024,16'h0000,1, 0,0,0,0);

        @(negedge clk);
        for (int i = 0; i < tab.size(); i++) step(tab[i], i);

        // reset asserted between clock edges must clear outputs immediately
        reset = 1'b1; start = 1'b0; bus.sel_valid = 1'b0;
        #1;
        chk("async_face_up", -2, face_up, 16'h0000);
        chk("async_moves",   -2, 16'(moves), 16'h0000);
        chk("async_flags",   -2, {12'h0, game_start, game_end, win, lose}, 16'h0000);
        ge_seen = 0;
        @(negedge clk);
        reset = 1'b0; bus.sel_valid = 1'b1; bus.card_sel = 4'd1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (game_end) ge_seen++;
        end
        bus.sel_valid = 1'b0;
        chk("no_game_end_after_reset", -3, 16'(ge_seen), 16'h0000);
        chk("idle_ignores_sel",        -3, face_up, 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
